wavetable_loader: RTL and testbench

WAVETABLE_LOADER -- requirements
Module: wavetable_loader

---
 rtl/wavetable_loader_pkg.sv | 27 ++
 rtl/wavetable_bank_ram.sv | 49 ++++
 rtl/wavetable_loader.sv | 137 +++++++++++++
 tb/tb_wavetable_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavetable_loader_pkg.sv
// ---------------------------------------------------------------------------
// mypackage
// Shared sizes and types for the wavetable loader and its bank RAMs.
//   WAVETABLE_N     : log2 of the table depth (read index width)
//   AMPLITUDE_BITS  : width of one stored sample
//   amplitude       : one sample word
//   phase_index_type: table index, used for rd_phase and the write address
//   load_state_t    : loader FSM states
// ---------------------------------------------------------------------------
package mypackage;

    localparam int WAVETABLE_N    = 5;
    localparam int AMPLITUDE_BITS = 8;
    localparam int TABLE_DEPTH    = 2 ** WAVETABLE_N;

    typedef logic [AMPLITUDE_BITS-1:0] amplitude;
    typedef logic [WAVETABLE_N-1:0]    phase_index_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2
    } load_state_t;

    localparam phase_index_type LAST_ADDR = phase_index_type'(TABLE_DEPTH - 1);

endpackage

// File: rtl/wavetable_bank_ram.sv
// ---------------------------------------------------------------------------
// wavetable_bank_ram
// One wavetable bank: a single synchronous write port and two registered
// read ports, so a caller can fetch neighbouring entries for interpolation.
// Ports:
//   clock, reset_n         : clock and async active-low reset (read regs only)
//   wr_en/wr_addr/wr_data  : write port
//   rd_addr_a/rd_addr_b    : read addresses, sampled every cycle
//   rd_data_a/rd_data_b    : registered read data, 1-cycle latency
// The storage array is deliberately not reset; only the output registers are.
// ---------------------------------------------------------------------------
module wavetable_bank_ram
    import mypackage::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wr_en,
    input  phase_index_type wr_addr,
    input  amplitude        wr_data,
    input  phase_index_type rd_addr_a,
    input  phase_index_type rd_addr_b,
    output amplitude        rd_data_a,
    output amplitude        rd_data_b
);

    amplitude mem [TABLE_DEPTH];
    amplitude rd_data_a_q;
    amplitude rd_data_b_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_data_a_q <= mem[rd_addr_a];
            rd_data_b_q <= mem[rd_addr_b];
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: rtl/wavetable_loader.sv
// ---------------------------------------------------------------------------
// wavetable_loader
// Double-buffered wavetable. A sample stream fills the shadow bank while the
// active bank keeps serving reads; once the shadow bank is complete the banks
// swap in a single cycle and load_done pulses.
// Ports:
//   clock, reset_n        : clock, async active-low reset
//   load_start, abort     : start / abandon a fill
//   s_valid/s_ready/s_data: sample stream into the shadow bank
//   load_busy, load_done  : fill/swap in progress, new table live pulse
//   active_bank           : bank currently serving reads
//   rd_phase              : read index; rd_a = table[rd_phase],
//                           rd_b = table[rd_phase+1] (wrapping), 1-cycle latency
// ---------------------------------------------------------------------------
module wavetable_loader
    import mypackage::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load_start,
    input  logic            abort,
    input  logic            s_valid,
    output logic            s_ready,
    input  amplitude        s_data,
    output logic            load_busy,
    output logic            load_done,
    output logic            active_bank,
    input  phase_index_type rd_phase,
    output amplitude        rd_a,
    output amplitude        rd_b
);

    load_state_t     state_q, state_d;
    phase_index_type waddr_q, waddr_d;
    logic            active_bank_q, active_bank_d;
    logic            load_done_q, load_done_d;
    logic            rd_sel_q;
    logic            wr_en;

    phase_index_type rd_phase_next;
    amplitude        bank0_a, bank0_b, bank1_a, bank1_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            waddr_q       <= '0;
            active_bank_q <= 1'b0;
            load_done_q   <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            waddr_q       <= waddr_d;
            active_bank_q <= active_bank_d;
            load_done_q   <= load_done_d;
            // The read registers sample the bank selected before this edge,
            // so the output mux has to follow that same, delayed selection.
            rd_sel_q      <= active_bank_q;
        end
    end

    // Abort takes priority over any handshake, including the final one, so an
    // aborted load never writes its last sample nor reaches SWAP.
    always_comb begin
        state_d       = state_q;
        waddr_d       = waddr_q;
        active_bank_d = active_bank_q;
        load_done_d   = 1'b0;
        wr_en         = 1'b0;
        s_ready       = 1'b0;
        load_busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = FILL;
                    waddr_d = '0;
                end
            end
            FILL: begin
                s_ready   = 1'b1;
                load_busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    waddr_d = '0;
                end else if (s_valid) begin
                    wr_en   = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                    if (waddr_q == LAST_ADDR) begin
                        state_d = SWAP;
                    end
                end
            end
            SWAP: begin
                load_busy     = 1'b1;
                active_bank_d = ~active_bank_q;
                load_done_d   = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_phase_next = rd_phase + 1'b1;

    // Writes only ever reach the bank that is not active, so the read ports
    // and write port never touch the same bank.
    wavetable_bank_ram u_bank0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en & active_bank_q),
        .wr_addr   (waddr_q),
        .wr_data   (s_data),
        .rd_addr_a (rd_phase),
        .rd_addr_b (rd_phase_next),
        .rd_data_a (bank0_a),
        .rd_data_b (bank0_b)
    );

    wavetable_bank_ram u_bank1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en & ~active_bank_q),
        .wr_addr   (waddr_q),
        .wr_data   (s_data),
        .rd_addr_a (rd_phase),
        .rd_addr_b (rd_phase_next),
        .rd_data_a (bank1_a),
        .rd_data_b (bank1_b)
    );

    assign rd_a        = rd_sel_q ? bank1_a : bank0_a;
    assign rd_b        = rd_sel_q ? bank1_b : bank0_b;
    assign load_done   = load_done_q;
    assign active_bank = active_bank_q;

endmodule

// File: tb/tb_wavetable_loader.sv
// ---------------------------------------------------------------------------
// tb_wavetable_loader
// Directed bench for wavetable_loader. Stimulus tasks push expected read data
// and expected load_done events into queues; a monitor pops and compares them
// whenever the DUT presents a read result or a load_done pulse.
// ---------------------------------------------------------------------------
module tb_wavetable_loader;
    import mypackage::*;

    logic            clock;
    logic            reset_n;
    logic            load_start;
    logic            abort;
    logic            s_valid;
    logic            s_ready;
    amplitude        s_data;
    logic            load_busy;
    logic            load_done;
    logic            active_bank;
    phase_index_type rd_phase;
    amplitude        rd_a;
    amplitude        rd_b;

    typedef struct {
        logic exp_bank;
        int   exp_cycle;
    } done_exp_t;

    typedef struct {
        int       phase;
        amplitude exp_a;
        amplitude exp_b;
    } rd_exp_t;

    done_exp_t done_q[$];
    rd_exp_t   rd_q[$];

    int   checks    = 0;
    int   errors    = 0;
    int   cycle_cnt = 0;
    logic rd_probe  = 1'b0;
    logic probe_d   = 1'b0;

    wavetable_loader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .active_bank (active_bank),
        .rd_phase    (rd_phase),
        .rd_a        (rd_a),
        .rd_b        (rd_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Cycle counter and read-probe pipeline: a probe driven before an edge
    // produces read data valid after that edge.
    always @(posedge clock) begin
        cycle_cnt = cycle_cnt + 1;
        probe_d   = rd_probe;
    end

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clock) begin
        rd_exp_t   r;
        done_exp_t d;
        if (probe_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_unexpected: got read result with no expectation queued");
            end else begin
                r = rd_q.pop_front();
                if (rd_a !== r.exp_a || rd_b !== r.exp_b) begin
                    errors++;
                    $display("[TB] FAIL rd_phase_%0d: got rd_a=%0h rd_b=%0h expected rd_a=%0h rd_b=%0h",
                             r.phase, rd_a, rd_b, r.exp_a, r.exp_b);
                end
            end
        end
        if (load_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL load_done_unexpected: got load_done=1 at cycle %0d expected 0", cycle_cnt);
            end else begin
                d = done_q.pop_front();
                if (active_bank !== d.exp_bank || cycle_cnt != d.exp_cycle) begin
                    errors++;
                    $display("[TB] FAIL load_done_event: got bank=%0d cycle=%0d expected bank=%0d cycle=%0d",
                             active_bank, cycle_cnt, d.exp_bank, d.exp_cycle);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic amplitude sampleValue(input int kind, input amplitude base, input int i);
        case (kind)
            0:       return amplitude'(i);
            2:       return amplitude'(TABLE_DEPTH - 1 - i);
            default: return base;
        endcase
    endfunction

    // Queue a read expectation and present rd_phase for one cycle.
    task automatic readCheck(input int phase, input amplitude exp_a, input amplitude exp_b);
        rd_exp_t r;
        r.phase  = phase;
        r.exp_a  = exp_a;
        r.exp_b  = exp_b;
        rd_q.push_back(r);
        rd_phase = phase_index_type'(phase);
        rd_probe = 1'b1;
        tick();
        rd_probe = 1'b0;
    endtask

    // Full or aborted table load. kind: 0 ramp, 1 constant, 2 reversed ramp.
    // gaps inserts an idle s_valid cycle before every odd sample; restart
    // raises load_start mid-fill, which must be ignored.
    task automatic applyStimulus(input int kind, input amplitude base, input int abort_at,
                                 input bit gaps, input bit restart, input logic exp_bank);
        done_exp_t d;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            if (gaps && (i % 2 == 1)) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
                tick();
            end
            s_valid    = 1'b1;
            s_data     = sampleValue(kind, base, i);
            abort      = (i == abort_at);
            load_start = (restart && i == 7);
            if (i == TABLE_DEPTH - 1 && abort_at < 0) begin
                d.exp_bank  = exp_bank;
                d.exp_cycle = cycle_cnt + 2;
                done_q.push_back(d);
            end
            tick();
            if (i == abort_at) break;
        end
        s_valid    = 1'b0;
        abort      = 1'b0;
        load_start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        load_start = 1'b0;
        abort      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        rd_phase   = '0;
        repeat (3) tick();
        $display("[TB] checking reset state");
        checkOutput("reset_s_ready", 32'(s_ready), 0);
        checkOutput("reset_load_busy", 32'(load_busy), 0);
        checkOutput("reset_load_done", 32'(load_done), 0);
        checkOutput("reset_active_bank", 32'(active_bank), 0);
        checkOutput("reset_rd_a", 32'(rd_a), 0);
        checkOutput("reset_rd_b", 32'(rd_b), 0);
        reset_n = 1'b1;
        repeat (2) tick();

        $display("[TB] ramp load into bank 1");
        applyStimulus(0, 8'h00, -1, 1'b0, 1'b0, 1'b1);
        checkOutput("ramp_active_bank", 32'(active_bank), 1);
        checkOutput("ramp_load_busy", 32'(load_busy), 0);
        readCheck(5, 8'd5, 8'd6);
        readCheck(TABLE_DEPTH - 1, 8'(TABLE_DEPTH - 1), 8'd0);
        readCheck(0, 8'd0, 8'd1);

        $display("[TB] abort at sample 10");
        applyStimulus(1, 8'h7F, 10, 1'b0, 1'b0, 1'b1);
        checkOutput("abort10_active_bank", 32'(active_bank), 1);
        checkOutput("abort10_load_busy", 32'(load_busy), 0);
        checkOutput("abort10_s_ready", 32'(s_ready), 0);
        readCheck(5, 8'd5, 8'd6);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("idle_abort_load_busy", 32'(load_busy), 0);

        $display("[TB] abort on final handshake");
        applyStimulus(1, 8'h22, TABLE_DEPTH - 1, 1'b0, 1'b0, 1'b1);
        checkOutput("abortlast_active_bank", 32'(active_bank), 1);
        readCheck(9, 8'd9, 8'd10);

        $display("[TB] constant 0x11 load into bank 0");
        applyStimulus(1, 8'h11, -1, 1'b0, 1'b0, 1'b0);
        checkOutput("const_active_bank", 32'(active_bank), 0);
        readCheck(5, 8'h11, 8'h11);
        readCheck(TABLE_DEPTH - 1, 8'h11, 8'h11);

        $display("[TB] reversed ramp with back-pressure");
        applyStimulus(2, 8'h00, -1, 1'b1, 1'b1, 1'b1);
        checkOutput("bp_active_bank", 32'(active_bank), 1);
        readCheck(0, 8'(TABLE_DEPTH - 1), 8'(TABLE_DEPTH - 2));
        readCheck(5, 8'(TABLE_DEPTH - 6), 8'(TABLE_DEPTH - 7));
        readCheck(TABLE_DEPTH - 1, 8'd0, 8'(TABLE_DEPTH - 1));

        $display("[TB] reset during fill");
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h55;
            tick();
        end
        checkOutput("midfill_s_ready", 32'(s_ready), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_active_bank", 32'(active_bank), 0);
        checkOutput("midreset_s_ready", 32'(s_ready), 0);
        checkOutput("midreset_load_busy", 32'(load_busy), 0);
        checkOutput("midreset_rd_a", 32'(rd_a), 0);
        checkOutput("midreset_rd_b", 32'(rd_b), 0);
        s_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (40) tick();
        checkOutput("postreset_active_bank", 32'(active_bank), 0);
        checkOutput("postreset_load_busy", 32'(load_busy), 0);

        repeat (2) tick();
        checkOutput("done_queue_empty", 32'(done_q.size()), 0);
        checkOutput("rd_queue_empty", 32'(rd_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
